// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: groups the mixer-side sample/mute inputs and the DAC-side
// serial pins of the I2S transmitter into one bundle.
interface audio_i2s_tx_if;
    logic [15:0] audio_l;       // signed left sample from the mixer
    logic [15:0] audio_r;       // signed right sample from the mixer
    logic        mute;          // 1 = ramp gain to 0, 0 = ramp to unity
    logic        i2s_bck;       // bit clock
    logic        i2s_lrck;      // word select, 0 = left slot
    logic        i2s_data;      // serial data, changes on BCK falling edge
    logic        frame_strobe;  // one-clk pulse when a new pair is latched
    logic        muted;         // 1 while gain is zero

    modport master (
        output audio_l, audio_r, mute,
        input  i2s_bck, i2s_lrck, i2s_data, frame_strobe, muted
    );

    modport slave (
        input  audio_l, audio_r, mute,
        output i2s_bck, i2s_lrck, i2s_data, frame_strobe, muted
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: serialises the mixer's signed 16-bit stereo pair onto I2S or
// left-justified DAC pins. BCK/LRCK are divided down from clk, one L/R pair is
// latched per frame and scaled by a 0..16 gain that ramps slowly for a
// click-free soft mute. Gain starts at 0 so the output always fades in.
module audio_i2s_tx #(
    parameter int BCK_DIV     = 8,
    parameter int SLOT_BITS   = 32,
    parameter int FMT         = 0,
    parameter int RAMP_FRAMES = 64
) (
    input  logic          clk,
    input  logic          reset,
    audio_i2s_tx_if.slave bus
);
    localparam int DIV_W  = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int BIT_W  = $clog2(2 * SLOT_BITS);
    localparam int RAMP_W = $clog2(RAMP_FRAMES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0]  SLOT_N     = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0]  K15        = BIT_W'(15);
    localparam logic [BIT_W-1:0]  K16        = BIT_W'(16);
    localparam logic [RAMP_W-1:0] RAMP_N     = RAMP_W'(RAMP_FRAMES);
    localparam logic [4:0]        GAIN_UNITY = 5'd16;

    // Scale a signed sample by gain/16; the 21-bit product cannot overflow
    // and the arithmetic shift rounds negative results toward -inf.
    function automatic logic [15:0] scale_sample(input logic [15:0] smp,
                                                 input logic [4:0]  g);
        logic signed [20:0] prod;
        prod = $signed({{5{smp[15]}}, smp}) * $signed({16'd0, g});
        return 16'(prod >>> 4);
    endfunction

    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_bck;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_lrck;
    logic              r_data;
    logic              r_frame_strobe;
    logic [15:0]       r_in_l;
    logic [15:0]       r_in_r;
    logic [15:0]       r_sh_l;
    logic [15:0]       r_sh_r;
    logic [RAMP_W-1:0] r_ramp_cnt;
    logic [4:0]        r_gain;
    logic              r_muted;

    logic              w_fall;
    logic              w_latch;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic              w_lrck_nxt;
    logic [BIT_W-1:0]  w_k;
    logic [15:0]       w_sh_l_nxt;
    logic [15:0]       w_sh_r_nxt;
    logic [15:0]       w_src;
    logic [3:0]        w_idx;
    logic              w_data_nxt;
    logic [RAMP_W-1:0] w_ramp_inc;
    logic              w_ramp_hit;
    logic [4:0]        w_gain_nxt;

    assign bus.i2s_bck      = r_bck;
    assign bus.i2s_lrck     = r_lrck;
    assign bus.i2s_data     = r_data;
    assign bus.frame_strobe = r_frame_strobe;
    assign bus.muted        = r_muted;

    // Detect the BCK falling edge and work out the slot position it moves to.
    always_comb begin
        w_fall = (r_div_cnt == DIV_LAST) && r_bck;
        if (r_bit_cnt == BIT_LAST) begin
            w_bit_nxt = {BIT_W{1'b0}};
        end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
        end
        w_latch    = w_fall && (r_bit_cnt == BIT_LAST);
        w_lrck_nxt = (w_bit_nxt >= SLOT_N);
        if (w_lrck_nxt) begin
            w_k = w_bit_nxt - SLOT_N;
        end else begin
            w_k = w_bit_nxt;
        end
    end

    // New scaled pair on the frame wrap; the first bit of the new frame must
    // already come from it, so the data mux looks at the next-state words.
    always_comb begin
        if (w_latch) begin
            w_sh_l_nxt = scale_sample(r_in_l, r_gain);
            w_sh_r_nxt = scale_sample(r_in_r, r_gain);
        end else begin
            w_sh_l_nxt = r_sh_l;
            w_sh_r_nxt = r_sh_r;
        end
        if (w_lrck_nxt) begin
            w_src = w_sh_r_nxt;
        end else begin
            w_src = w_sh_l_nxt;
        end
    end

    // Pick the serial bit for the slot position: I2S delays the MSB by one
    // BCK, left-justified puts it on the LRCK edge; the slot tail is zero.
    always_comb begin
        w_idx      = 4'd0;
        w_data_nxt = 1'b0;
        if (FMT == 0) begin
            if ((w_k != {BIT_W{1'b0}}) && (w_k <= K16)) begin
                w_idx      = 4'(K16 - w_k);
                w_data_nxt = w_src[w_idx];
            end else begin
                w_data_nxt = 1'b0;
            end
        end else begin
            if (w_k <= K15) begin
                w_idx      = 4'(K15 - w_k);
                w_data_nxt = w_src[w_idx];
            end else begin
                w_data_nxt = 1'b0;
            end
        end
    end

    // Gain ramp: one step every RAMP_FRAMES latches, direction from mute.
    always_comb begin
        w_ramp_inc = r_ramp_cnt + RAMP_W'(1);
        w_ramp_hit = (w_ramp_inc == RAMP_N);
        w_gain_nxt = r_gain;
        if (w_latch && w_ramp_hit) begin
            if (bus.mute) begin
                if (r_gain != 5'd0) begin
                    w_gain_nxt = r_gain - 5'd1;
                end else begin
                    w_gain_nxt = r_gain;
                end
            end else begin
                if (r_gain < GAIN_UNITY) begin
                    w_gain_nxt = r_gain + 5'd1;
                end else begin
                    w_gain_nxt = r_gain;
                end
            end
        end else begin
            w_gain_nxt = r_gain;
        end
    end

    // Clock divider producing BCK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= {DIV_W{1'b0}};
            r_bck     <= 1'b0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= {DIV_W{1'b0}};
            r_bck     <= ~r_bck;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Slot counter, word select and serial data, all moving on BCK falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= {BIT_W{1'b0}};
            r_lrck    <= 1'b0;
            r_data    <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_lrck    <= w_lrck_nxt;
            r_data    <= w_data_nxt;
        end
    end

    // Input sample registers, refreshed every clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_l <= 16'd0;
            r_in_r <= 16'd0;
        end else begin
            r_in_l <= bus.audio_l;
            r_in_r <= bus.audio_r;
        end
    end

    // Frame shift words and the latch strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_l         <= 16'd0;
            r_sh_r         <= 16'd0;
            r_frame_strobe <= 1'b0;
        end else begin
            r_sh_l         <= w_sh_l_nxt;
            r_sh_r         <= w_sh_r_nxt;
            r_frame_strobe <= w_latch;
        end
    end

    // Ramp counter, gain and muted flag; muted tracks the gain it reports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ramp_cnt <= {RAMP_W{1'b0}};
            r_gain     <= 5'd0;
            r_muted    <= 1'b1;
        end else begin
            if (w_latch) begin
                if (w_ramp_hit) begin
                    r_ramp_cnt <= {RAMP_W{1'b0}};
                end else begin
                    r_ramp_cnt <= w_ramp_inc;
                end
            end
            r_gain  <= w_gain_nxt;
            r_muted <= (w_gain_nxt == 5'd0);
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: four transmitter instances with different parameter sets
// run side by side. A timeline model derives every output from the number of
// clk edges since reset release; a negedge process compares all outputs of
// all instances every cycle. Literal expectations pin the model's latched
// words and gain trajectory, plus a few direct looks at the pins.
module tb_audio_i2s_tx;
    localparam int P_BD  [4] = '{8, 1, 1, 2};
    localparam int P_S   [4] = '{32, 32, 16, 16};
    localparam int P_FMT [4] = '{0, 0, 0, 1};
    localparam int P_RF  [4] = '{64, 1, 4, 1};

    logic        clk = 1'b0;
    logic [3:0]  rst = 4'hF;
    logic [15:0] in_l [4];
    logic [15:0] in_r [4];
    logic [3:0]  mute = 4'h0;
    logic [3:0]  o_bck, o_lrck, o_data, o_fs, o_muted;

    int checks = 0;
    int errors = 0;

    // values the DUTs saw at the last posedge
    logic [3:0]  cap_rst  = 4'hF;
    logic [3:0]  cap_mute = 4'h0;
    logic [15:0] cap_l [4];
    logic [15:0] cap_r [4];

    // model state
    int          m_n    [4];
    int          m_gain [4];
    int          m_ramp [4];
    int          m_lat  [4];
    logic [15:0] m_shl  [4];
    logic [15:0] m_shr  [4];
    logic [15:0] m_pl   [4];
    logic [15:0] m_pr   [4];

    always #5 clk = ~clk;

    audio_i2s_tx_if if0 ();
    audio_i2s_tx_if if1 ();
    audio_i2s_tx_if if2 ();
    audio_i2s_tx_if if3 ();

    audio_i2s_tx #(.BCK_DIV(P_BD[0]), .SLOT_BITS(P_S[0]), .FMT(P_FMT[0]), .RAMP_FRAMES(P_RF[0]))
        u0 (.clk(clk), .reset(rst[0]), .bus(if0));
    audio_i2s_tx #(.BCK_DIV(P_BD[1]), .SLOT_BITS(P_S[1]), .FMT(P_FMT[1]), .RAMP_FRAMES(P_RF[1]))
        u1 (.clk(clk), .reset(rst[1]), .bus(if1));
    audio_i2s_tx #(.BCK_DIV(P_BD[2]), .SLOT_BITS(P_S[2]), .FMT(P_FMT[2]), .RAMP_FRAMES(P_RF[2]))
        u2 (.clk(clk), .reset(rst[2]), .bus(if2));
    audio_i2s_tx #(.BCK_DIV(P_BD[3]), .SLOT_BITS(P_S[3]), .FMT(P_FMT[3]), .RAMP_FRAMES(P_RF[3]))
        u3 (.clk(clk), .reset(rst[3]), .bus(if3));

    assign if0.audio_l = in_l[0]; assign if0.audio_r = in_r[0]; assign if0.mute = mute[0];
    assign if1.audio_l = in_l[1]; assign if1.audio_r = in_r[1]; assign if1.mute = mute[1];
    assign if2.audio_l = in_l[2]; assign if2.audio_r = in_r[2]; assign if2.mute = mute[2];
    assign if3.audio_l = in_l[3]; assign if3.audio_r = in_r[3]; assign if3.mute = mute[3];

    assign o_bck   = {if3.i2s_bck, if2.i2s_bck, if1.i2s_bck, if0.i2s_bck};
    assign o_lrck  = {if3.i2s_lrck, if2.i2s_lrck, if1.i2s_lrck, if0.i2s_lrck};
    assign o_data  = {if3.i2s_data, if2.i2s_data, if1.i2s_data, if0.i2s_data};
    assign o_fs    = {if3.frame_strobe, if2.frame_strobe, if1.frame_strobe, if0.frame_strobe};
    assign o_muted = {if3.muted, if2.muted, if1.muted, if0.muted};

    function automatic void chk(string nm, int i, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) begin
                $display("FAIL %s u%0d t=%0t got %h expected %h", nm, i, $time, act, exp);
            end
        end
    endfunction

    // gain/16 with floor rounding, in plain integer arithmetic
    function automatic logic [15:0] ref_scale(logic [15:0] s, int g);
        int v;
        v = int'($signed(s)) * g;
        v = v >>> 4;
        return v[15:0];
    endfunction

    function automatic void model_reset(int i);
        m_n[i] = 0; m_gain[i] = 0; m_ramp[i] = 0; m_lat[i] = 0;
        m_shl[i] = 16'h0000; m_shr[i] = 16'h0000;
        m_pl[i] = 16'h0000; m_pr[i] = 16'h0000;
    endfunction

    // one clk edge of the model
    function automatic void model_edge(int i);
        int per;
        int g;
        int eg;
        m_n[i]++;
        per = 2 * P_BD[i];
        if ((m_n[i] % per) == 0 && ((m_n[i] / per) % (2 * P_S[i])) == 0) begin
            g = m_gain[i];
            m_shl[i] = ref_scale(m_pl[i], g);
            m_shr[i] = ref_scale(m_pr[i], g);
            m_lat[i]++;
            m_ramp[i]++;
            if (m_ramp[i] == P_RF[i]) begin
                m_ramp[i] = 0;
                if (cap_mute[i] && m_gain[i] > 0) m_gain[i]--;
                else if (!cap_mute[i] && m_gain[i] < 16) m_gain[i]++;
            end
            if (i == 1 && g == 16 && m_pl[i] == 16'h7FFF) begin
                chk("full_l", i, m_shl[i], 16'h7FFF);
                chk("full_r", i, m_shr[i], 16'h8000);
            end
            if (i == 1 && g == 8 && m_pl[i] == 16'h4000) begin
                chk("half_l", i, m_shl[i], 16'h2000);
                chk("half_r", i, m_shr[i], 16'hFFFF);
            end
            if (i == 1 && m_lat[i] == 16) chk("gain_at16", i, 16'(m_gain[i]), 16'd16);
            if (i == 3 && g == 16) chk("lj_word", i, m_shl[i], 16'hA5A5);
            if (i == 2 && (m_lat[i] % 4) == 0 && m_lat[i] <= 128) begin
                eg = (m_lat[i] <= 64) ? (m_lat[i] / 4) : (16 - (m_lat[i] - 64) / 4);
                chk("ramp4", i, 16'(m_gain[i]), 16'(eg));
            end
        end
        m_pl[i] = cap_l[i];
        m_pr[i] = cap_r[i];
    endfunction

    function automatic void check_outputs(int i);
        int n, bd, s, f, bitp, k;
        logic [15:0] src;
        logic e_bck, e_lrck, e_data, e_fs, e_muted;
        n = m_n[i]; bd = P_BD[i]; s = P_S[i];
        e_bck  = ((n / bd) % 2) == 1;
        f      = n / (2 * bd);
        bitp   = f % (2 * s);
        e_lrck = bitp >= s;
        k      = bitp % s;
        src    = e_lrck ? m_shr[i] : m_shl[i];
        e_data = 1'b0;
        if (P_FMT[i] == 0) begin
            if (k >= 1 && k <= 16) e_data = src[16 - k];
        end else begin
            if (k <= 15) e_data = src[15 - k];
        end
        e_fs    = (n > 0) && ((n % (4 * bd * s)) == 0);
        e_muted = (m_gain[i] == 0);
        chk("bck",   i, {15'd0, o_bck[i]},   {15'd0, e_bck});
        chk("lrck",  i, {15'd0, o_lrck[i]},  {15'd0, e_lrck});
        chk("data",  i, {15'd0, o_data[i]},  {15'd0, e_data});
        chk("fs",    i, {15'd0, o_fs[i]},    {15'd0, e_fs});
        chk("muted", i, {15'd0, o_muted[i]}, {15'd0, e_muted});
    endfunction

    // record what each DUT sampled at this edge
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            cap_rst[i]  <= rst[i];
            cap_mute[i] <= mute[i];
            cap_l[i]    <= in_l[i];
            cap_r[i]    <= in_r[i];
        end
    end

    // advance the model and compare every output on the falling clk edge
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst[i]) model_reset(i);
            else if (!cap_rst[i]) model_edge(i);
            check_outputs(i);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pin(string nm, int i, logic act, logic exp);
        chk(nm, i, {15'd0, act}, {15'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_l[i] = 16'h0000; in_r[i] = 16'h0000;
            cap_l[i] = 16'h0000; cap_r[i] = 16'h0000;
            model_reset(i);
        end
        fork
            begin : default_timing
                in_l[0] = 16'h1234; in_r[0] = 16'hEDCB; mute[0] = 1'b0;
                step(3);
                rst[0] = 1'b0;
                step(7);  pin("bck_pre_rise", 0, o_bck[0], 1'b0);
                step(1);  pin("bck_rise", 0, o_bck[0], 1'b1);
                pin("muted_start", 0, o_muted[0], 1'b1);
                step(1632 - 8);
                pin("lrck_right", 0, o_lrck[0], 1'b1);
                rst[0] = 1'b1;
                #1;
                pin("rst_bck", 0, o_bck[0], 1'b0);
                pin("rst_lrck", 0, o_lrck[0], 1'b0);
                pin("rst_data", 0, o_data[0], 1'b0);
                pin("rst_fs", 0, o_fs[0], 1'b0);
                pin("rst_muted", 0, o_muted[0], 1'b1);
                step(3);
                rst[0] = 1'b0;
                step(7);  pin("bck_pre_rise2", 0, o_bck[0], 1'b0);
                step(1);  pin("bck_rise2", 0, o_bck[0], 1'b1);
                step(1100);
            end
            begin : ramp_fast
                in_l[1] = 16'h7FFF; in_r[1] = 16'h8000; mute[1] = 1'b0;
                step(3);
                rst[1] = 1'b0;
                step(20 * 128);
                pin("fs_latch20", 1, o_fs[1], 1'b1);
                pin("unmuted", 1, o_muted[1], 1'b0);
                mute[1] = 1'b1; in_l[1] = 16'h4000; in_r[1] = 16'hFFFE;
                step(20 * 128);
                pin("muted_end", 1, o_muted[1], 1'b1);
            end
            begin : ramp_slow
                in_l[2] = 16'h1357; in_r[2] = 16'h9BDF; mute[2] = 1'b0;
                step(3);
                rst[2] = 1'b0;
                step(66 * 64);
                pin("unmuted", 2, o_muted[2], 1'b0);
                mute[2] = 1'b1;
                step(70 * 64);
                pin("muted_end", 2, o_muted[2], 1'b1);
            end
            begin : left_justified
                in_l[3] = 16'hA5A5; in_r[3] = 16'h5A5A; mute[3] = 1'b0;
                step(3);
                rst[3] = 1'b0;
                step(20 * 128);
                pin("lj_fs", 3, o_fs[3], 1'b1);
                pin("lj_lrck", 3, o_lrck[3], 1'b0);
                pin("lj_msb", 3, o_data[3], 1'b1);
            end
        join
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
